// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a 32-bit word as 8N1 UART bytes, [31:24] first.
// Define UART_WORD_TX_CRLF_EN to append CR (0x0D) and LF (0x0A) after every word.
module uart_word_tx #(
   parameter int CLK_FREQ  = 27000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word_in,
   input  logic        valid,
   output logic        ready,
   output logic        done,
   output logic        tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef UART_WORD_TX_CRLF_EN
   localparam int SHIFT_W   = 48;
   localparam int NUM_BYTES = 6;
`else
   localparam int SHIFT_W   = 32;
   localparam int NUM_BYTES = 4;
`endif
   localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_word_tx: CLK_FREQ / BAUD_RATE must be at least 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [SHIFT_W-1:0]   shift_r, shift_s, load_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [2:0]           bit_idx_r, bit_idx_s, bit_idx_nxt_s;
   logic [3:0]           byte_idx_r, byte_idx_s;
   logic                 tx_r, tx_s;
   logic                 ready_r, ready_s;
   logic                 done_r, done_s;
   logic                 bit_end_s;
   logic [7:0]           cur_byte_s;

`ifdef UART_WORD_TX_CRLF_EN
   assign load_s = {word_in, 8'h0D, 8'h0A};
`else
   assign load_s = word_in;
`endif

   // The byte on the wire always sits in the top eight bits of the shift register.
   assign cur_byte_s    = shift_r[SHIFT_W-1 -: 8];
   assign bit_end_s     = (cnt_r == CNT_MAX);
   assign bit_idx_nxt_s = bit_idx_r + 3'd1;

   // Next-state and next-output logic for the framing FSM.
   always_comb begin
      state_s    = state_r;
      shift_s    = shift_r;
      cnt_s      = cnt_r;
      bit_idx_s  = bit_idx_r;
      byte_idx_s = byte_idx_r;
      tx_s       = tx_r;
      ready_s    = ready_r;
      done_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            tx_s  = 1'b1;
            cnt_s = CNT_ZERO;
            if (valid && ready_r) begin
               state_s    = ST_START;
               shift_s    = load_s;
               tx_s       = 1'b0;
               ready_s    = 1'b0;
               byte_idx_s = 4'd0;
               bit_idx_s  = 3'd0;
            end else begin
               ready_s = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_s   = ST_DATA;
               cnt_s     = CNT_ZERO;
               bit_idx_s = 3'd0;
               tx_s      = cur_byte_s[0];
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               cnt_s = CNT_ZERO;
               if (bit_idx_r == 3'd7) begin
                  state_s = ST_STOP;
                  tx_s    = 1'b1;
               end else begin
                  bit_idx_s = bit_idx_nxt_s;
                  tx_s      = cur_byte_s[bit_idx_nxt_s];
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               cnt_s = CNT_ZERO;
               if (byte_idx_r == LAST_BYTE) begin
                  state_s = ST_IDLE;
                  done_s  = 1'b1;
                  ready_s = 1'b1;
                  tx_s    = 1'b1;
               end else begin
                  // Next start bit begins immediately: no idle time between bytes.
                  state_s    = ST_START;
                  byte_idx_s = byte_idx_r + 4'd1;
                  shift_s    = {shift_r[SHIFT_W-9:0], 8'h00};
                  tx_s       = 1'b0;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            tx_s    = 1'b1;
            ready_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         shift_r    <= {SHIFT_W{1'b0}};
         cnt_r      <= CNT_ZERO;
         bit_idx_r  <= 3'd0;
         byte_idx_r <= 4'd0;
         tx_r       <= 1'b1;
         ready_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         shift_r    <= shift_s;
         cnt_r      <= cnt_s;
         bit_idx_r  <= bit_idx_s;
         byte_idx_r <= byte_idx_s;
         tx_r       <= tx_s;
         ready_r    <= ready_s;
         done_r     <= done_s;
      end
   end

   assign tx    = tx_r;
   assign ready = ready_r;
   assign done  = done_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench for uart_word_tx at 4 clocks per bit.
// Honours UART_WORD_TX_CRLF_EN (six bytes per word instead of four).
module tb_uart_word_tx;

   localparam int C = 4;
`ifdef UART_WORD_TX_CRLF_EN
   localparam int NB = 6;
`else
   localparam int NB = 4;
`endif
   localparam int FRAME_CLKS = NB * 10 * C;

   logic        clk;
   logic        rst;
   logic [31:0] word_in;
   logic        valid;
   logic        ready;
   logic        done;
   logic        tx;

   int n_checks;
   int n_errors;

   logic [7:0] exp_b [6];

   uart_word_tx #(.CLK_FREQ(4), .BAUD_RATE(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .word_in (word_in),
      .valid   (valid),
      .ready   (ready),
      .done    (done),
      .tx      (tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line level t clocks after the accepting edge.
   function automatic logic exp_bit(input int t);
      int s;
      int b;
      int p;
      logic [7:0] byte_v;
      s = t / C;
      b = s / 10;
      p = s % 10;
      byte_v = exp_b[b];
      if (p == 0) return 1'b0;
      else if (p == 9) return 1'b1;
      else return byte_v[p-1];
   endfunction

   task automatic send_word(input string tag, input logic [31:0] w, input bit hold,
                            input int poke_cyc, input logic [31:0] poke_w);
      word_in = w;
      valid   = 1'b1;
      tick();
      if (!hold) valid = 1'b0;
      for (int t = 0; t < FRAME_CLKS; t++) begin
         check({tag, "_tx"}, {31'd0, tx}, {31'd0, exp_bit(t)});
         check({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
         check({tag, "_done_busy"}, {31'd0, done}, 32'd0);
         if (poke_cyc >= 0 && t == poke_cyc) begin
            word_in = poke_w;
            valid   = 1'b1;
         end else if (poke_cyc >= 0 && t == poke_cyc + 1) begin
            valid = 1'b0;
         end
         tick();
      end
      check({tag, "_done_end"}, {31'd0, done}, 32'd1);
      check({tag, "_ready_end"}, {31'd0, ready}, 32'd1);
      check({tag, "_tx_end"}, {31'd0, tx}, 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      valid    = 1'b0;
      word_in  = 32'h0000_0000;
      exp_b    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};

      repeat (3) tick();
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_rel_ready", {31'd0, ready}, 32'd1);
      check("rst_rel_tx", {31'd0, tx}, 32'd1);

      // "pass": single-cycle valid, done at clock 160.
      exp_b[0] = 8'h70; exp_b[1] = 8'h61; exp_b[2] = 8'h73; exp_b[3] = 8'h73;
      send_word("pass", 32'h7061_7373, 1'b0, -1, 32'h0);
      tick();
      check("pass_done_pulse", {31'd0, done}, 32'd0);
      check("pass_idle_tx", {31'd0, tx}, 32'd1);

      // Back-to-back words with valid held high; the new start bit follows done directly.
      exp_b[0] = 8'h30; exp_b[1] = 8'h30; exp_b[2] = 8'h30; exp_b[3] = 8'h30;
      send_word("b2b0", 32'h3030_3030, 1'b1, -1, 32'h0);
      exp_b[0] = 8'h31; exp_b[1] = 8'h31; exp_b[2] = 8'h31; exp_b[3] = 8'h31;
      send_word("b2b1", 32'h3131_3131, 1'b0, -1, 32'h0);
      tick();
      check("b2b_done_pulse", {31'd0, done}, 32'd0);

      // "fail": word_in and valid poked mid-frame must not disturb the frame.
      exp_b[0] = 8'h66; exp_b[1] = 8'h61; exp_b[2] = 8'h69; exp_b[3] = 8'h6C;
      send_word("fail", 32'h6661_696C, 1'b0, 10, 32'hFFFF_FFFF);
      tick();
      check("fail_done_pulse", {31'd0, done}, 32'd0);
      check("fail_idle_ready", {31'd0, ready}, 32'd1);

      // Reset at clock 50 of a frame.
      word_in = 32'h7061_7373;
      valid   = 1'b1;
      tick();
      valid = 1'b0;
      repeat (50) tick();
      check("mid_busy_ready", {31'd0, ready}, 32'd0);
      rst = 1'b1;
      tick();
      check("mid_rst_tx", {31'd0, tx}, 32'd1);
      check("mid_rst_ready", {31'd0, ready}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();
      check("mid_rel_ready", {31'd0, ready}, 32'd1);
      for (int t = 0; t < FRAME_CLKS; t++) begin
         check("mid_quiet_done", {31'd0, done}, 32'd0);
         check("mid_quiet_tx", {31'd0, tx}, 32'd1);
         tick();
      end

      // rst together with valid: the word is dropped.
      word_in = 32'h5555_5555;
      rst     = 1'b1;
      valid   = 1'b1;
      tick();
      check("rstv_tx", {31'd0, tx}, 32'd1);
      check("rstv_ready", {31'd0, ready}, 32'd0);
      rst   = 1'b0;
      valid = 1'b0;
      tick();
      check("rstv_rel_ready", {31'd0, ready}, 32'd1);
      for (int t = 0; t < 8; t++) begin
         check("rstv_quiet_tx", {31'd0, tx}, 32'd1);
         tick();
      end

      // "ABCD": with CR/LF enabled this frame is six bytes and done lands at clock 240.
      exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43; exp_b[3] = 8'h44;
      send_word("abcd", 32'h4142_4344, 1'b0, -1, 32'h0);
      tick();
      check("abcd_done_pulse", {31'd0, done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
